// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package loader_pkg;

   typedef enum logic [2:0] {
      COLLECT,
      EVAL,
      WR_PEND,
      WR_WORD,
      DONE
   } state_t;

   localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

   // Width of the byte-lane index within a 32-bit word
   localparam int LANE_W = 2;
   localparam logic [LANE_W-1:0] LAST_LANE = '1;

endpackage

// File: rtl/uart_imem_loader_if.sv
// UART byte stream in and instruction-memory write port out, bundled for the loader.
interface uart_imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              uart_rx_valid;
   logic [7:0]        uart_rx_data;
   logic              uart_rx_break;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   // master: the environment feeding bytes and receiving memory writes
   modport master (
      output uart_rx_valid, uart_rx_data, uart_rx_break,
      input  imem_we, imem_addr, imem_wdata
   );

   // slave: the loader itself
   modport slave (
      input  uart_rx_valid, uart_rx_data, uart_rx_break,
      output imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/uart_imem_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words; optional inter-byte
// timeout when LOADER_TIMEOUT_EN is defined.
module loader_word_packer
   import loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_break,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [LANE_W-1:0] byte_idx_reg;
   logic              accept;
   logic              discard;
   logic              timeout_hit;

   assign accept     = enable && rx_valid && !rx_break;
   assign discard    = enable && (rx_break || timeout_hit);
   // Strobe on the 4th byte; the full word is readable from `word` next cycle
   assign word_valid = accept && (byte_idx_reg == LAST_LANE);

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx_reg <= '0;
      end else if (discard) begin
         byte_idx_reg <= '0;
      end else if (accept) begin
         byte_idx_reg <= byte_idx_reg + LANE_W'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               lane_reg <= '0;
            end else if (accept && (byte_idx_reg == LANE_W'(gi))) begin
               lane_reg <= rx_data;
            end
         end
         assign word[gi*8 +: 8] = lane_reg;
      end
   endgenerate

`ifdef LOADER_TIMEOUT_EN
   logic [16:0] idle_cnt_reg;

   assign timeout_hit = enable && (byte_idx_reg != '0) && !accept
                        && (idle_cnt_reg == 17'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_reg <= '0;
      end else if (accept || discard || !enable || (byte_idx_reg == '0)) begin
         idle_cnt_reg <= '0;
      end else begin
         idle_cnt_reg <= idle_cnt_reg + 17'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: UART bytes -> instruction memory, holds the core in reset until
// the double FFFF_FFFF end marker. Optional feature macro: LOADER_TIMEOUT_EN.
module uart_imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                clk,
   input  logic                rst,
   uart_imem_loader_if.slave   bus,
   output logic                cpu_rst,
   output logic                write_done,
   output logic                overflow,
   output logic [ADDR_W:0]     word_count
);

   localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_W:0]   COUNT_ONE = 1;

   state_t              state_reg, state_next;
   logic                pending_reg, pending_next;
   logic                we_reg, we_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [31:0]         wdata_reg, wdata_next;
   logic [ADDR_W:0]     count_reg, count_next;
   logic                overflow_reg, overflow_next;
   logic                done_reg, done_next;
   logic                word_valid;
   logic [31:0]         word;
   logic                addr_last;

   loader_word_packer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .enable     (state_reg == COLLECT),
      .rx_valid   (bus.uart_rx_valid),
      .rx_data    (bus.uart_rx_data),
      .rx_break   (bus.uart_rx_break),
      .word_valid (word_valid),
      .word       (word)
   );

   assign addr_last = (addr_reg == '1);

   always_comb begin
      state_next    = state_reg;
      pending_next  = pending_reg;
      we_next       = 1'b0;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;

      case (state_reg)
         COLLECT: begin
            if (bus.uart_rx_break) begin
               pending_next = 1'b0;
            end else if (word_valid) begin
               state_next = EVAL;
            end
         end
         EVAL: begin
            // The write pulse is launched here so it lines up with WR_PEND/WR_WORD
            if (word == END_MARKER) begin
               if (pending_reg) begin
                  state_next = DONE;
               end else begin
                  pending_next = 1'b1;
                  state_next   = COLLECT;
               end
            end else if (pending_reg) begin
               state_next = WR_PEND;
               we_next    = 1'b1;
               wdata_next = END_MARKER;
            end else begin
               state_next = WR_WORD;
               we_next    = 1'b1;
               wdata_next = word;
            end
         end
         WR_PEND: begin
            addr_next    = addr_reg + ADDR_ONE;
            count_next   = count_reg + COUNT_ONE;
            pending_next = 1'b0;
            if (addr_last) begin
               state_next    = DONE;
               overflow_next = 1'b1;
            end else begin
               state_next = WR_WORD;
               we_next    = 1'b1;
               wdata_next = word;
            end
         end
         WR_WORD: begin
            addr_next  = addr_reg + ADDR_ONE;
            count_next = count_reg + COUNT_ONE;
            if (addr_last) begin
               state_next    = DONE;
               overflow_next = 1'b1;
            end else begin
               state_next = COLLECT;
            end
         end
         DONE: begin
            state_next = DONE;
         end
         default: begin
            state_next = COLLECT;
         end
      endcase

      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= COLLECT;
         pending_reg  <= 1'b0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pending_reg  <= pending_next;
         we_reg       <= we_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
         done_reg     <= done_next;
      end
   end

   assign bus.imem_we    = we_reg;
   assign bus.imem_addr  = addr_reg;
   assign bus.imem_wdata = wdata_reg;
   assign cpu_rst        = !done_reg;
   assign write_done     = done_reg;
   assign overflow       = overflow_reg;
   assign word_count     = count_reg;

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Boot-time controller between the UART receiver and the instruction memory of the core wrapper.
- Assembles received bytes into 32-bit little-endian instruction words and writes them to consecutive instruction-memory addresses.
- Detects the end-of-program marker, two consecutive 32'hFFFF_FFFF words.
- Holds the processor core in reset until loading completes, then releases it and raises `write_done`.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT_CYCLES`, 65535: inter-byte timeout in `clk` cycles. Used only with `LOADER_TIMEOUT_EN`.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  reset. **Synchronous, active-high.**
- `uart_rx_valid`  in  1  one-cycle strobe: `uart_rx_data` holds a new byte.
- `uart_rx_data`  in  8  received byte.
- `uart_rx_break`  in  1  one-cycle strobe: a BREAK condition was detected on the line.
- `imem_we`  out  1  instruction-memory write enable; one-cycle pulse per word.
- `imem_addr`  out  ADDR_W  word address of the current write.
- `imem_wdata`  out  32  instruction word being written.
- `cpu_rst`  out  1  active-high reset to the core; 1 until loading is done.
- `write_done`  out  1  level; 1 once loading has completed.
- `overflow`  out  1  level; 1 if loading stopped because memory was full.
- `word_count`  out  ADDR_W+1  number of words committed to memory.

## Operation
**Reset values:** `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `write_done`=0, `overflow`=0, `word_count`=0. Byte index=0, pending flag=0, state=COLLECT.

**States**
- COLLECT
  - Each `uart_rx_valid` stores the byte into lane `byte_idx`: the first byte goes to [7:0], the fourth to [31:24].
  - On the 4th byte, go to EVAL.
- EVAL (one cycle)
  - Word is 32'hFFFF_FFFF and pending=1: go to DONE. Neither marker word is written.
  - Word is 32'hFFFF_FFFF and pending=0: set pending=1, return to COLLECT. Nothing is written.
  - Word is anything else and pending=1: go to WR_PEND.
  - Word is anything else and pending=0: go to WR_WORD.
- WR_PEND
  - Write 32'hFFFF_FFFF at `imem_addr`, clear pending, go to WR_WORD.
  - A lone FFFF_FFFF is therefore a legal instruction word.
- WR_WORD
  - Write the assembled word, then go to COLLECT.
- DONE
  - `cpu_rst`=0, `write_done`=1.
  - All further `uart_rx_valid` and `uart_rx_break` inputs are ignored.
  - DONE is left only by `rst`.

**Every write cycle:** `imem_we`=1. `imem_addr` increments and `word_count` increments after the write.

**Memory full:** if a write occurs at address 2^ADDR_W−1, the next state is DONE with `overflow`=1. `imem_addr` wraps to 0 but is never written again.

**Break:** `uart_rx_break` in COLLECT
- Discards a partial word: `byte_idx` returns to 0.
- Clears pending.
- Does not change the address.

**Simultaneous `uart_rx_valid` and `uart_rx_break`:** break wins and the byte is dropped.

**Bytes arriving outside COLLECT:** `uart_rx_valid` in EVAL, WR_PEND or WR_WORD is dropped. At UART rates a byte cannot arrive within three cycles of the previous one, so this is a defined protocol violation, not a supported case.

**Reset mid-load:** all state is discarded, loading restarts at address 0, and `cpu_rst` is reasserted.

## Timing
- Latency from the `uart_rx_valid` carrying the 4th byte to the `imem_we` pulse:
  - 2 cycles for a normal word (EVAL, then WR_WORD);
  - 2 cycles for the pending marker (WR_PEND), followed by the word itself on the 3rd cycle.
- `imem_addr` and `imem_wdata` are registered and valid in the same cycle as `imem_we`.
- `cpu_rst` deasserts and `write_done` asserts 1 cycle after the second marker word's EVAL cycle.
- `cpu_rst` and `write_done` change in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `LOADER_TIMEOUT_EN`.
- **Defined:**
  - A 17-bit counter clears on every accepted byte.
  - It counts while in COLLECT with `byte_idx`≠0.
  - On reaching `TIMEOUT_CYCLES`, the partial word is discarded exactly as on a break. Pending is unaffected.
- **Undefined:** no counter exists, and a partial word waits indefinitely.

## Structure
- Package `loader_pkg` holds:
  - the state enum (COLLECT, EVAL, WR_PEND, WR_WORD, DONE);
  - the constant `END_MARKER`=32'hFFFF_FFFF;
  - the lane-index width constant.
- One sub-module, `loader_word_packer`:
  - contains the byte-lane shift/assemble register, `byte_idx`, and the optional timeout counter;
  - outputs `word_valid` and `word`.
- The FSM, address counter, pending flag and output registers live in the top level.

## Test plan
- Send bytes 13,01,01,FB → exactly one `imem_we` pulse with addr 0, data 32'hFB010113, 2 cycles after the last strobe; `word_count`=1.
- Send 3 words, then FFFFFFFF, FFFFFFFF → three writes at addr 0–2; `write_done`=1 and `cpu_rst`=0; `word_count`=3; bytes sent afterwards cause no writes.
- Send word A, then FFFFFFFF, then word B → consecutive write pulses with FFFFFFFF@1 and B@2; `write_done` stays 0.
- Send 2 bytes, pulse `uart_rx_break`, then send 4 bytes of 32'h00000013 → a single write of 32'h00000013@0. Also pulse `uart_rx_valid` and `uart_rx_break` in the same cycle → the byte is dropped.
- With `ADDR_W`=2, send 4 words → the write at addr 3 is followed by `write_done`=1 and `overflow`=1; a 5th word is not written.
- Assert `rst` for 1 cycle after 2 words → `cpu_rst`=1, `word_count`=0; the next word is written at addr 0. With `LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, send 2 bytes, idle 100 cycles, send 4 bytes → a single write of the later 4-byte word.
